// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RV32I-subset datapath.
// Fetch/decode/execute/memory/writeback with bus timeout and trap.
module multicycle_control #(
  parameter int WIDTH       = 32,
  parameter int CNT_WIDTH   = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     instr,
  input  logic                 EQ,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 PCsrc,
  output logic                 RegWrite,
  output logic                 ALUsrc,
  output logic [2:0]           ALUctrl,
  output logic [1:0]           ImmSrc,
  output logic                 ResultSrc,
  output logic                 illegal,
  output logic                 bus_error,
  output logic [CNT_WIDTH-1:0] retired_count,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC = 3'd2,
    S_MEM = 3'd3,
    S_WB = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

  state_t st, st_n;

  // Only the decode fields of the instruction are kept.
  logic [6:0] ir_op;
  logic [2:0] ir_f3;
  logic [6:0] ir_f7;
  logic [7:0] wcnt;

  logic unused_bits;
  assign unused_bits = ^{instr[24:15], instr[11:7]};

  logic is_addi, is_add, is_sub;
  logic is_beq, is_bne, is_lw, is_sw;
  logic is_alu, is_br, is_ls, legal;
  logic taken, wait_st, tmo;
  logic retire, set_ill, set_bus;

  assign is_addi = ir_op == 7'd19 && ir_f3 == 3'd0;
  assign is_add = ir_op == 7'd51 && ir_f3 == 3'd0
               && ir_f7 == 7'h00;
  assign is_sub = ir_op == 7'd51 && ir_f3 == 3'd0
               && ir_f7 == 7'h20;
  assign is_beq = ir_op == 7'd99 && ir_f3 == 3'd0;
  assign is_bne = ir_op == 7'd99 && ir_f3 == 3'd1;
  assign is_lw = ir_op == 7'd3 && ir_f3 == 3'd2;
  assign is_sw = ir_op == 7'd35 && ir_f3 == 3'd2;

  assign is_alu = is_add | is_sub;
  assign is_br = is_beq | is_bne;
  assign is_ls = is_lw | is_sw;
  assign legal = is_addi | is_alu | is_br | is_ls;

  assign taken = is_beq ? EQ : ~EQ;
  assign wait_st = st == S_FETCH || st == S_MEM;
  assign tmo = ~mem_ready && wcnt == LIMIT;
  assign state = st;

  always_comb begin
    st_n = st;
    mem_req = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    PCWrite = 1'b0;
    PCsrc = 1'b0;
    RegWrite = 1'b0;
    ALUsrc = 1'b0;
    ALUctrl = 3'b000;
    ImmSrc = 2'b00;
    ResultSrc = 1'b0;
    retire = 1'b0;
    set_ill = 1'b0;
    set_bus = 1'b0;
    unique case (st)
      S_FETCH: begin
        mem_req = 1'b1;
        // No IR load may slip through while reset is held.
        IRWrite = mem_ready & ~rst;
        if (mem_ready) begin
          st_n = S_DECODE;
        end else if (tmo) begin
          st_n = S_TRAP;
          set_bus = 1'b1;
        end
      end
      S_DECODE: begin
        st_n = legal ? S_EXEC : S_TRAP;
        set_ill = ~legal;
      end
      S_EXEC: begin
        unique case (1'b1)
          is_addi: begin
            ALUsrc = 1'b1;
            st_n = S_WB;
          end
          is_alu: begin
            ALUctrl = is_sub ? 3'b001 : 3'b000;
            st_n = S_WB;
          end
          is_br: begin
            ALUctrl = 3'b001;
            ImmSrc = 2'b10;
            PCWrite = 1'b1;
            PCsrc = taken;
            retire = 1'b1;
            st_n = S_FETCH;
          end
          is_ls: begin
            ALUsrc = 1'b1;
            ImmSrc = is_sw ? 2'b01 : 2'b00;
            st_n = S_MEM;
          end
          default: st_n = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        MemWrite = is_sw;
        ALUsrc = 1'b1;
        ImmSrc = is_sw ? 2'b01 : 2'b00;
        if (mem_ready) begin
          if (is_sw) begin
            PCWrite = 1'b1;
            retire = 1'b1;
            st_n = S_FETCH;
          end else begin
            st_n = S_WB;
          end
        end else if (tmo) begin
          st_n = S_TRAP;
          set_bus = 1'b1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite = 1'b1;
        ResultSrc = is_lw;
        retire = 1'b1;
        st_n = S_FETCH;
      end
      S_TRAP: st_n = S_TRAP;
      default: st_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= S_FETCH;
      ir_op <= '0;
      ir_f3 <= '0;
      ir_f7 <= '0;
      wcnt <= '0;
      retired_count <= '0;
      illegal <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      st <= st_n;
      if (IRWrite) begin
        ir_op <= instr[6:0];
        ir_f3 <= instr[14:12];
        ir_f7 <= instr[31:25];
      end
      // Wait counter restarts on every state entry.
      if (st_n != st)
        wcnt <= '0;
      else if (wait_st && !mem_ready)
        wcnt <= wcnt + 8'd1;
      if (retire)
        retired_count <= retired_count + 1'b1;
      if (set_ill)
        illegal <= 1'b1;
      if (set_bus)
        bus_error <= 1'b1;
    end
  end

endmodule
